// File: rtl/bloom_pkg.sv
// Shared types and helpers for the counting Bloom filter.
//   bloom_op_e    : request opcodes (PROBE/INSERT/DELETE/CLEAR)
//   bloom_state_e : controller states (IDLE/WALK/CLEAR/RESP)
//   hash_idx()    : bucket index for hash slice k (caller truncates to LOG_SIZE bits)
package bloom_pkg;

  typedef enum logic [1:0] {
    OP_PROBE  = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_CLEAR  = 2'd3
  } bloom_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_CLEAR,
    ST_RESP
  } bloom_state_e;

  // Widest request address the hash helper accepts.
  localparam int unsigned ADDR_MAX = 128;

  // Slice k starts at page_offset + k*stride; the low LOG_SIZE bits of the
  // result are the bucket index.
  function automatic logic [ADDR_MAX-1:0] hash_idx(
    input logic [ADDR_MAX-1:0] addr,
    input int unsigned         k,
    input int unsigned         page_offset,
    input int unsigned         stride
  );
    return addr >> (page_offset + k * stride);
  endfunction

endpackage

// File: rtl/bloom_counter_bank.sv
// SIZE x CNT_W saturating counter array with one read-modify-write port.
//   clk_i/rst_ni : clock, async active-low reset (all counters to 0)
//   idx_i        : bucket index for read and write
//   op_i         : INSERT increments, DELETE decrements, others leave value
//   en_i         : apply op_i to bucket idx_i on this edge
//   clr_i        : zero bucket idx_i on this edge (wins over en_i)
//   old_o        : current (pre-update) value of bucket idx_i
//   sat_o        : old_o is all-ones
//   zero_o       : old_o is zero
module bloom_counter_bank
  import bloom_pkg::*;
#(
  parameter int unsigned SIZE     = 8192,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned LOG_SIZE = $clog2(SIZE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [LOG_SIZE-1:0] idx_i,
  input  bloom_op_e           op_i,
  input  logic                en_i,
  input  logic                clr_i,
  output logic [CNT_W-1:0]    old_o,
  output logic                sat_o,
  output logic                zero_o
);

  logic [CNT_W-1:0] cnt_q [SIZE];
  logic [CNT_W-1:0] new_d;

  assign old_o  = cnt_q[idx_i];
  assign sat_o  = (old_o == '1);
  assign zero_o = (old_o == '0);

  // Saturated buckets are sticky: neither incremented nor decremented.
  always_comb begin
    new_d = old_o;
    unique case (op_i)
      OP_INSERT: if (!sat_o)            new_d = old_o + 1'b1;
      OP_DELETE: if (!sat_o && !zero_o) new_d = old_o - 1'b1;
      default:   new_d = old_o;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SIZE; i++) cnt_q[i] <= '0;
    end else if (clr_i) begin
      cnt_q[idx_i] <= '0;
    end else if (en_i) begin
      cnt_q[idx_i] <= new_d;
    end
  end

endmodule

// File: rtl/counting_bloom_filter.sv
// Counting Bloom filter for page-granular address membership.
// Ports:
//   CLK, rstb            : clock, async active-low reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_op, req_addr     : opcode (PROBE/INSERT/DELETE/CLEAR) and address
//   rsp_valid            : one-cycle response pulse
//   rsp_hit, rsp_err     : result flags, held until the next response
//   occupancy            : nonzero bucket count
// Build option: define BLOOM_OCCUPANCY_EN to generate the occupancy tracker;
// otherwise occupancy is tied to zero.
module counting_bloom_filter
  import bloom_pkg::*;
#(
  parameter int unsigned ADDR_W      = 57,
  parameter int unsigned PAGE_OFFSET = 12,
  parameter int unsigned SIZE        = 8192,
  parameter int unsigned HASH_COUNT  = 1,
  parameter int unsigned HASH_STRIDE = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                   CLK,
  input  logic                   rstb,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic                   rsp_err,
  output logic [$clog2(SIZE):0]  occupancy
);

  localparam int unsigned      LOG_SIZE = $clog2(SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - 1'b1;

  if (PAGE_OFFSET + (HASH_COUNT - 1) * HASH_STRIDE + LOG_SIZE > ADDR_W) begin : g_bad_slices
    $error("hash slices exceed ADDR_W");
  end
  if (HASH_COUNT < 1 || HASH_COUNT > 4) begin : g_bad_hash_count
    $error("HASH_COUNT must be 1..4");
  end
  if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
    $error("SIZE must be a power of two >= 2");
  end
  if (ADDR_W > ADDR_MAX) begin : g_bad_addr_w
    $error("ADDR_W exceeds ADDR_MAX");
  end

  bloom_state_e        state_q, state_d;
  bloom_op_e           op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          k_q, k_d;
  logic [LOG_SIZE-1:0] clr_q, clr_d;
  logic                acc_hit_q, acc_hit_d;
  logic                acc_err_q, acc_err_d;
  logic                hit_q, hit_d;
  logic                err_q, err_d;

  logic [LOG_SIZE-1:0] walk_idx, bank_idx;
  logic                bank_en, bank_clr;
  logic [CNT_W-1:0]    bank_old;
  logic                bank_sat, bank_zero;
  logic                slice_err, hit_step, err_step;

  assign walk_idx = LOG_SIZE'(hash_idx(ADDR_MAX'(addr_q), 32'(k_q), PAGE_OFFSET, HASH_STRIDE));

  bloom_counter_bank #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_bank (
    .clk_i  (CLK),
    .rst_ni (rstb),
    .idx_i  (bank_idx),
    .op_i   (op_q),
    .en_i   (bank_en),
    .clr_i  (bank_clr),
    .old_o  (bank_old),
    .sat_o  (bank_sat),
    .zero_o (bank_zero)
  );

  // INSERT flags a bucket that is at max after the update; DELETE flags an
  // underflow attempt. Both use the pre-update value of this slice.
  always_comb begin
    slice_err = 1'b0;
    unique case (op_q)
      OP_INSERT: slice_err = bank_sat || (bank_old == CNT_NEAR);
      OP_DELETE: slice_err = bank_zero;
      default:   slice_err = 1'b0;
    endcase
  end

  assign hit_step = acc_hit_q & ~bank_zero;
  assign err_step = acc_err_q | slice_err;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    k_d       = k_q;
    clr_d     = clr_q;
    acc_hit_d = acc_hit_q;
    acc_err_d = acc_err_q;
    hit_d     = hit_q;
    err_d     = err_q;
    bank_idx  = walk_idx;
    bank_en   = 1'b0;
    bank_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d      = bloom_op_e'(req_op);
          addr_d    = req_addr;
          k_d       = '0;
          clr_d     = '0;
          acc_hit_d = 1'b1;
          acc_err_d = 1'b0;
          state_d   = (bloom_op_e'(req_op) == OP_CLEAR) ? ST_CLEAR : ST_WALK;
        end
      end
      ST_WALK: begin
        bank_en = 1'b1;
        // The response flags only change on the way into RESP, so they hold
        // their previous values while a walk is in progress.
        if (k_q == 2'(HASH_COUNT - 1)) begin
          hit_d   = hit_step;
          err_d   = err_step;
          state_d = ST_RESP;
        end else begin
          k_d       = k_q + 1'b1;
          acc_hit_d = hit_step;
          acc_err_d = err_step;
        end
      end
      ST_CLEAR: begin
        bank_clr = 1'b1;
        bank_idx = clr_q;
        if (clr_q == LOG_SIZE'(SIZE - 1)) begin
          hit_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_PROBE;
      addr_q    <= '0;
      k_q       <= '0;
      clr_q     <= '0;
      acc_hit_q <= 1'b0;
      acc_err_q <= 1'b0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      k_q       <= k_d;
      clr_q     <= clr_d;
      acc_hit_q <= acc_hit_d;
      acc_err_q <= acc_err_d;
      hit_q     <= hit_d;
      err_q     <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_hit   = hit_q;
  assign rsp_err   = err_q;

`ifdef BLOOM_OCCUPANCY_EN
  logic [LOG_SIZE:0] occ_q, occ_d;

  // Track 0<->nonzero transitions of the bucket being written. CLEAR
  // decrements once per nonzero bucket, so it ends at zero.
  always_comb begin
    occ_d = occ_q;
    if (bank_clr) begin
      if (!bank_zero) occ_d = occ_q - 1'b1;
    end else if (bank_en) begin
      if (op_q == OP_INSERT && bank_zero) begin
        occ_d = occ_q + 1'b1;
      end else if (op_q == OP_DELETE && !bank_sat && bank_old == CNT_W'(1)) begin
        occ_d = occ_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`else
  assign occupancy = '0;
`endif

endmodule

// File: tb/tb_counting_bloom_filter.sv
// Directed self-checking bench for counting_bloom_filter
// (SIZE=16, HASH_COUNT=2, CNT_W=2, PAGE_OFFSET=12, HASH_STRIDE=15).
module tb_counting_bloom_filter;

  localparam int unsigned ADDR_W = 57;

`ifdef BLOOM_OCCUPANCY_EN
  localparam bit OCC = 1'b1;
`else
  localparam bit OCC = 1'b0;
`endif

  localparam logic [1:0] OPP = 2'd0;
  localparam logic [1:0] OPI = 2'd1;
  localparam logic [1:0] OPD = 2'd2;
  localparam logic [1:0] OPC = 2'd3;

  localparam logic [ADDR_W-1:0] A = 57'h0800_3000; // buckets 3,1
  localparam logic [ADDR_W-1:0] B = 57'h0000_5000; // buckets 5,0
  localparam logic [ADDR_W-1:0] D = 57'h1000_2000; // buckets 2,2

  logic              CLK = 1'b0;
  logic              rstb = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              rsp_valid, rsp_hit, rsp_err;
  logic [4:0]        occupancy;

  int total = 0;
  int bad   = 0;

  counting_bloom_filter #(
    .ADDR_W      (ADDR_W),
    .PAGE_OFFSET (12),
    .SIZE        (16),
    .HASH_COUNT  (2),
    .HASH_STRIDE (15),
    .CNT_W       (2)
  ) dut (
    .CLK       (CLK),
    .rstb      (rstb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_err   (rsp_err),
    .occupancy (occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int unsigned i);
    return 32'(dut.u_bank.cnt_q[i]);
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    rstb = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rstb = 1'b1;
  endtask

  // Issue one request from IDLE, then count cycles (negedges) after the
  // accept edge until rsp_valid, and how many of those had req_ready low.
  task automatic do_req(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        output logic hit, output logic err,
                        output int lat, output int busy);
    logic done;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    lat = 0; busy = 0; hit = 1'bx; err = 1'bx; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      lat++;
      if (!req_ready) busy++;
      if (rsp_valid) begin
        hit = rsp_hit; err = rsp_err; done = 1'b1;
      end
    end
  endtask

  initial begin
    logic h, e;
    int   lat, busy;
    logic done;

    // Reset state
    do_reset();
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_hit", 32'(rsp_hit), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_occ", 32'(occupancy), 0);

    // PROBE on an empty filter
    do_req(OPP, A, h, e, lat, busy);
    chk("probe0_lat", 32'(lat), 3);
    chk("probe0_hit", 32'(h), 0);
    chk("probe0_err", 32'(e), 0);
    chk("probe0_occ", 32'(occupancy), 0);

    // INSERT then PROBE
    do_req(OPI, A, h, e, lat, busy);
    chk("ins1_lat", 32'(lat), 3);
    chk("ins1_hit", 32'(h), 0);
    chk("ins1_err", 32'(e), 0);
    chk("ins1_cnt3", cnt(3), 1);
    chk("ins1_cnt1", cnt(1), 1);
    chk("ins1_occ", 32'(occupancy), OCC ? 2 : 0);
    do_req(OPP, A, h, e, lat, busy);
    chk("probe1_hit", 32'(h), 1);
    chk("probe1_err", 32'(e), 0);

    // Three more inserts: 1->2, 2->3 (now at max), 3->3
    do_req(OPI, A, h, e, lat, busy);
    chk("ins2_hit", 32'(h), 1);
    chk("ins2_err", 32'(e), 0);
    do_req(OPI, A, h, e, lat, busy);
    chk("ins3_err", 32'(e), 1);
    do_req(OPI, A, h, e, lat, busy);
    chk("ins4_err", 32'(e), 1);
    chk("ins4_cnt3", cnt(3), 3);
    chk("ins4_cnt1", cnt(1), 3);
    chk("ins4_occ", 32'(occupancy), OCC ? 2 : 0);

    // DELETE on saturated buckets leaves them saturated
    do_req(OPD, A, h, e, lat, busy);
    chk("delsat_hit", 32'(h), 1);
    chk("delsat_err", 32'(e), 0);
    chk("delsat_cnt3", cnt(3), 3);
    chk("delsat_cnt1", cnt(1), 3);
    do_req(OPP, A, h, e, lat, busy);
    chk("probe2_hit", 32'(h), 1);

    // DELETE on an empty filter underflows
    do_reset();
    do_req(OPD, A, h, e, lat, busy);
    chk("del0_hit", 32'(h), 0);
    chk("del0_err", 32'(e), 1);
    chk("del0_cnt3", cnt(3), 0);
    chk("del0_cnt1", cnt(1), 0);
    chk("del0_occ", 32'(occupancy), 0);

    // INSERT B then CLEAR
    do_req(OPI, B, h, e, lat, busy);
    chk("insB_cnt5", cnt(5), 1);
    chk("insB_cnt0", cnt(0), 1);
    chk("insB_occ", 32'(occupancy), OCC ? 2 : 0);
    do_req(OPC, '0, h, e, lat, busy);
    chk("clr_lat", 32'(lat), 17);
    chk("clr_busy", 32'(busy), 17);
    chk("clr_hit", 32'(h), 0);
    chk("clr_err", 32'(e), 0);
    chk("clr_cnt5", cnt(5), 0);
    chk("clr_cnt0", cnt(0), 0);
    chk("clr_occ", 32'(occupancy), 0);

    // req_valid held (with a different address) while busy is not accepted
    @(posedge CLK); #1;
    req_valid = 1'b1; req_op = OPI; req_addr = A;
    @(posedge CLK); #1;
    req_addr = B;
    lat = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      lat++;
      if (rsp_valid) begin
        done = 1'b1;
        req_valid = 1'b0;
      end
    end
    chk("hold_lat", 32'(lat), 3);
    repeat (2) @(negedge CLK);
    chk("hold_ready", 32'(req_ready), 1);
    chk("hold_cnt3", cnt(3), 1);
    chk("hold_cnt5", cnt(5), 0);
    chk("hold_cnt0", cnt(0), 0);
    chk("hold_occ", 32'(occupancy), OCC ? 2 : 0);

    // Reset asserted mid-WALK
    @(posedge CLK); #1;
    req_valid = 1'b1; req_op = OPI; req_addr = B;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    chk("walk_busy", 32'(req_ready), 0);
    @(negedge CLK);
    rstb = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready), 1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    @(posedge CLK); #1;
    chk("midrst_ready2", 32'(req_ready), 1);
    chk("midrst_cnt3", cnt(3), 0);
    chk("midrst_cnt5", cnt(5), 0);
    chk("midrst_occ", 32'(occupancy), 0);
    @(negedge CLK);
    rstb = 1'b1;

    // Both slices land on the same bucket: updated twice
    do_req(OPI, D, h, e, lat, busy);
    chk("dup_hit", 32'(h), 0);
    chk("dup_err", 32'(e), 0);
    chk("dup_cnt2", cnt(2), 2);
    chk("dup_occ", 32'(occupancy), OCC ? 1 : 0);
    do_req(OPP, D, h, e, lat, busy);
    chk("dup_probe_hit", 32'(h), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
